// File: rtl/psram_wb_arbiter.sv
// Two-master Wishbone classic arbiter in front of a single-port PSRAM controller.
// The winning request is latched so the slave sees stable attributes until it acks.
// One idle cycle always follows an ack, because the slave needs cyc&stb low to re-arm.
module psram_wb_arbiter #(
    parameter int FIXED_PRIO = 0,   // 0: round-robin, 1: m0 wins simultaneous requests
    parameter int ADR_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // master 0
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [31:0]      m0_dat_i,
    input  logic [3:0]       m0_sel_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic [31:0]      m0_dat_o,
    output logic             m0_ack_o,
    // master 1
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [31:0]      m1_dat_i,
    input  logic [3:0]       m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic [31:0]      m1_dat_o,
    output logic             m1_ack_o,
    // slave port
    output logic [ADR_W-1:0] s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [31:0]      s_dat_i,
    input  logic             s_ack_i,
    // status
    output logic             busy_o,
    output logic             grant_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic [ADR_W-1:0]   adr_q,   adr_d;
    logic [31:0]        dat_q,   dat_d;
    logic [3:0]         sel_q,   sel_d;
    logic               we_q,    we_d;

    logic               m0_req;
    logic               m1_req;
    logic               winner;

    assign m0_req = m0_cyc_i & m0_stb_i;
    assign m1_req = m1_cyc_i & m1_stb_i;

    // Pick the master to serve; only consulted in IDLE. On contention the
    // round-robin pointer favours the master that was not granted last.
    always_comb begin
        winner = 1'b0;
        if (m0_req && m1_req) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~grant_q;
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    // Next-state logic: grant and latch attributes from IDLE, leave BUSY on ack.
    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        grant_d = grant_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = BUSY;
                    grant_d = winner;
                    adr_d   = winner ? m1_adr_i : m0_adr_i;
                    dat_d   = winner ? m1_dat_i : m0_dat_i;
                    sel_d   = winner ? m1_sel_i : m0_sel_i;
                    we_d    = winner ? m1_we_i  : m0_we_i;
                end
            end
            BUSY: begin
                if (s_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-attribute registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= 1'b1;    // m0 wins the first round-robin contest
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
        end
    end

    assign busy_o  = (state_q == BUSY);
    assign s_cyc_o = busy_o;
    assign s_stb_o = busy_o;
    assign s_adr_o = adr_q;
    assign s_dat_o = dat_q;
    assign s_sel_o = sel_q;
    assign s_we_o  = we_q;
    assign grant_o = grant_q;

    // Ack goes only to the granted master, and only if it is still requesting.
    assign m0_ack_o = s_ack_i & busy_o & ~grant_q & m0_req;
    assign m1_ack_o = s_ack_i & busy_o &  grant_q & m1_req;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
